// File: rtl/lpc_sniffer_pkg.sv
// Shared types and constants for the LPC sniffer record path.
// Holds the scheduler state encoding and the terminator/saturation constants.
package lpc_sniffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_TERM
    } sched_state_e;

    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h0a;
    localparam logic [7:0] OVF_SAT           = 8'hff;

endpackage

// File: rtl/lpc_record_fifo.sv
// DEPTH x AW register FIFO, async active-low reset.
// Ports: push/push_data in, pop in, pop_data (head) out, full/empty out.
module lpc_record_fifo #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // Pointers are log2(DEPTH) bits, so they wrap naturally.
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lpc_record_scheduler.sv
// Queues captured LPC records and drains each MSB-first as bytes plus a terminator.
// Ports: clock/reset, capture_enable/in_data/in_valid in, tx_* handshake out, FIFO flags, overflow_count.
module lpc_record_scheduler
    import lpc_sniffer_pkg::*;
#(
    parameter int         AW        = 32,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          capture_enable,
    input  logic [AW-1:0] in_data,
    input  logic          in_valid,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [7:0]    overflow_count
);

    localparam int NB  = AW / 8;
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BIW-1:0] BI_LAST = BIW'(NB - 1);

    sched_state_e   state_q, state_d;
    logic [AW-1:0]  shift_q, shift_d;
    logic [BIW-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]     ovf_q, ovf_d;
    logic           wr_req;
    logic           fifo_pop;
    logic [AW-1:0]  fifo_head;

    assign wr_req         = capture_enable && in_valid;
    assign overflow_count = ovf_q;

    lpc_record_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_req),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Full is the pre-edge flag, so a strobe is dropped even if LOAD pops now.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_req && fifo_full && (ovf_q != OVF_SAT)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        fifo_pop   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d    = fifo_head;
                fifo_pop   = 1'b1;
                byte_idx_d = BI_LAST;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[AW-1 -: 8];
                if (tx_ready) begin
                    shift_d = shift_q << 8;
                    if (byte_idx_q == '0) begin
                        state_d = ST_TERM;
                    end else begin
                        byte_idx_d = byte_idx_q - 1'b1;
                    end
                end
            end
            ST_TERM: begin
                tx_valid = 1'b1;
                tx_data  = TERM_BYTE;
                if (tx_ready) begin
                    state_d = fifo_empty ? ST_IDLE : ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            byte_idx_q <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_lpc_record_scheduler.sv
// Directed self-checking bench for lpc_record_scheduler.
// Drives records, watches the byte stream, compares against hand-derived values.
module tb_lpc_record_scheduler;

    logic        clock;
    logic        reset;
    logic        capture_enable;
    logic [31:0] in_data;
    logic        in_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  overflow_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    lpc_record_scheduler #(
        .AW        (32),
        .DEPTH     (4),
        .TERM_BYTE (8'h0a)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .capture_enable (capture_enable),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .overflow_count (overflow_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every byte the UART accepts.
    always @(posedge clock) begin
        if (reset && tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_rec(input logic [31:0] d);
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(d[i*8 +: 8]);
        end
        exp_q.push_back(8'h0a);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        tx_ready       = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        capture_enable = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    logic [17:0] vtrace;
    int          vcount;

    initial begin
        // Reset state
        do_reset();
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_ovf", 32'(overflow_count), 32'h0);

        // Single record with latency
        tx_ready = 1'b1;
        strobe(32'hDEADBEEF);
        chk("lat_e0_valid", 32'(tx_valid), 32'h0);
        chk("lat_e0_empty", 32'(fifo_empty), 32'h0);
        tick();
        chk("lat_e1_valid", 32'(tx_valid), 32'h0);
        tick();
        chk("lat_e2_valid", 32'(tx_valid), 32'h1);
        chk("lat_e2_data", 32'(tx_data), 32'hDE);
        chk("lat_e2_empty", 32'(fifo_empty), 32'h1);
        tick();
        chk("b1", 32'(tx_data), 32'hAD);
        tick();
        chk("b2", 32'(tx_data), 32'hBE);
        tick();
        chk("b3", 32'(tx_data), 32'hEF);
        tick();
        chk("term", 32'(tx_data), 32'h0A);
        chk("term_valid", 32'(tx_valid), 32'h1);
        tick();
        chk("idle_valid", 32'(tx_valid), 32'h0);
        chk("idle_empty", 32'(fifo_empty), 32'h1);
        push_rec(32'hDEADBEEF);
        chk_stream("single");

        // Backpressure on second byte
        do_reset();
        tx_ready = 1'b1;
        strobe(32'hDEADBEEF);
        tick();
        tick();
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_v%0d", i), 32'(tx_valid), 32'h1);
            chk($sformatf("bp_hold_d%0d", i), 32'(tx_data), 32'hAD);
            tick();
        end
        tx_ready = 1'b1;
        repeat (6) tick();
        push_rec(32'hDEADBEEF);
        chk_stream("bp");

        // Overflow: r0 in shift, r1..r4 queued, r5 dropped
        do_reset();
        for (int i = 0; i < 6; i++) begin
            strobe(32'hA0B0C0D0 + 32'(i) * 32'h01010101);
        end
        chk("ovf_full", 32'(fifo_full), 32'h1);
        chk("ovf_cnt", 32'(overflow_count), 32'h1);
        chk("ovf_valid", 32'(tx_valid), 32'h1);
        chk("ovf_head", 32'(tx_data), 32'hA0);
        tx_ready = 1'b1;
        repeat (40) tick();
        for (int i = 0; i < 5; i++) begin
            push_rec(32'hA0B0C0D0 + 32'(i) * 32'h01010101);
        end
        chk_stream("ovf");
        chk("ovf_drained", 32'(fifo_empty), 32'h1);

        // Gating then saturation
        do_reset();
        capture_enable = 1'b0;
        for (int i = 0; i < 10; i++) strobe(32'h55555555);
        chk("gate_empty", 32'(fifo_empty), 32'h1);
        chk("gate_valid", 32'(tx_valid), 32'h0);
        chk("gate_ovf", 32'(overflow_count), 32'h0);
        capture_enable = 1'b1;
        for (int i = 0; i < 5; i++) strobe(32'h12345678);
        chk("sat_full", 32'(fifo_full), 32'h1);
        chk("sat_ovf0", 32'(overflow_count), 32'h0);
        for (int i = 0; i < 254; i++) strobe(32'h12345678);
        chk("sat_254", 32'(overflow_count), 32'd254);
        for (int i = 0; i < 46; i++) strobe(32'h12345678);
        chk("sat_255", 32'(overflow_count), 32'd255);
        capture_enable = 1'b0;
        for (int i = 0; i < 10; i++) strobe(32'h12345678);
        chk("sat_gate", 32'(overflow_count), 32'd255);

        // Back-to-back drain: exactly one gap cycle between records
        do_reset();
        strobe(32'h01020304);
        strobe(32'h05060708);
        strobe(32'h090A0B0C);
        tx_ready = 1'b1;
        vtrace = '0;
        for (int i = 17; i >= 0; i--) begin
            vtrace[i] = tx_valid;
            tick();
        end
        chk("b2b_trace", 32'(vtrace), 32'(18'b111110111110111110));
        push_rec(32'h01020304);
        push_rec(32'h05060708);
        push_rec(32'h090A0B0C);
        chk_stream("b2b");

        // Reset in the middle of a record
        do_reset();
        tx_ready = 1'b1;
        strobe(32'h11223344);
        strobe(32'hAAAAAAAA);
        strobe(32'hBBBBBBBB);
        tick();
        chk("mid_byte2", 32'(tx_data), 32'h22);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valid_async", 32'(tx_valid), 32'h0);
        #2;
        reset = 1'b1;
        got_q.delete();
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (tx_valid) vcount++;
        end
        chk("mid_empty", 32'(fifo_empty), 32'h1);
        chk("mid_ovf", 32'(overflow_count), 32'h0);
        chk("mid_no_valid", 32'(vcount), 32'h0);
        chk("mid_no_bytes", 32'(got_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
